// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the raster timing generator.
// axis_t describes one scan axis (active, front porch, sync, back porch).
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    localparam vga_axis_t VGA_640X480_H = '{active: 32'd640, fp: 32'd16, sync: 32'd96, bp: 32'd48};
    localparam vga_axis_t VGA_640X480_V = '{active: 32'd480, fp: 32'd10, sync: 32'd2,  bp: 32'd33};

    // Total period of one axis in counts (pixels per line or lines per frame).
    function automatic int unsigned axis_total(input vga_axis_t axis);
        return axis.active + axis.fp + axis.sync + axis.bp;
    endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Pixel-domain bundle between the timing generator and its consumers.
// Optional macro VTG_FRAME_CNT_EN adds the frame_count signal.
interface vga_timing_generator_if #(
    parameter int CNT_W = 12
);
    logic             pix_en;
    logic             vga_h_sync;
    logic             vga_v_sync;
    logic             de;
    logic             h_blank;
    logic             v_blank;
    logic             line_start;
    logic             frame_start;
    logic [CNT_W-1:0] pos_x;
    logic [CNT_W-1:0] pos_y;
`ifdef VTG_FRAME_CNT_EN
    logic [7:0]       frame_count;
`endif

    // Consumer side: supplies the pixel enable, receives timing.
    modport master (
        output pix_en,
`ifdef VTG_FRAME_CNT_EN
        input  frame_count,
`endif
        input  vga_h_sync,
        input  vga_v_sync,
        input  de,
        input  h_blank,
        input  v_blank,
        input  line_start,
        input  frame_start,
        input  pos_x,
        input  pos_y
    );

    // Generator side.
    modport slave (
        input  pix_en,
`ifdef VTG_FRAME_CNT_EN
        output frame_count,
`endif
        output vga_h_sync,
        output vga_v_sync,
        output de,
        output h_blank,
        output v_blank,
        output line_start,
        output frame_start,
        output pos_x,
        output pos_y
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus combinational decode of
// the terminal count, sync window and blanking region for the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_en,
    input  vga_axis_t        timing,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync_active,
    output logic             blank
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] active_end_s;
    logic [CNT_W-1:0] sync_first_s;
    logic [CNT_W-1:0] sync_last_s;
    logic [CNT_W-1:0] last_s;

    // Axis landmarks expressed in counter units.
    always_comb begin
        active_end_s = CNT_W'(timing.active);
        sync_first_s = CNT_W'(timing.active + timing.fp);
        sync_last_s  = CNT_W'(timing.active + timing.fp + timing.sync - 32'd1);
        last_s       = CNT_W'(axis_total(timing) - 32'd1);
    end

    // Position counter: advances on cnt_en and returns to 0 after the last count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (cnt_en) begin
            if (count_r == last_s) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
        end
    end

    assign count       = count_r;
    assign wrap        = (count_r == last_s);
    assign sync_active = (count_r >= sync_first_s) && (count_r <= sync_last_s);
    assign blank       = (count_r >= active_end_s);

endmodule

// File: rtl/vga_timing_generator.sv
// Parametrised raster timing generator (default 640x480@60).
// Two axis counters produce a position snapshot; every output is registered
// from that snapshot on pix_en so sync/blank/DE/strobes and pos_x/pos_y align.
// Optional macro VTG_FRAME_CNT_EN adds an 8-bit completed-frame counter.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640X480_H.active,
    parameter int unsigned H_FP     = VGA_640X480_H.fp,
    parameter int unsigned H_SYNC   = VGA_640X480_H.sync,
    parameter int unsigned H_BP     = VGA_640X480_H.bp,
    parameter int unsigned V_ACTIVE = VGA_640X480_V.active,
    parameter int unsigned V_FP     = VGA_640X480_V.fp,
    parameter int unsigned V_SYNC   = VGA_640X480_V.sync,
    parameter int unsigned V_BP     = VGA_640X480_V.bp,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int          CNT_W    = 12
) (
    input logic                   clk,
    input logic                   rst_n,
    vga_timing_generator_if.slave vif
);
    localparam vga_axis_t H_AXIS = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam vga_axis_t V_AXIS = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

    localparam int unsigned     H_TOTAL   = axis_total(H_AXIS);
    localparam int unsigned     V_TOTAL   = axis_total(V_AXIS);
    localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

    // A counter that cannot reach TOTAL-1 would silently alias the raster.
    if ((64'(H_TOTAL) > CNT_RANGE) || (64'(V_TOTAL) > CNT_RANGE)) begin : g_cnt_w_too_small
        $error("vga_timing_generator: CNT_W too narrow for H_TOTAL or V_TOTAL");
    end

    logic             pix_en_s;
    logic [CNT_W-1:0] hcnt_s;
    logic [CNT_W-1:0] vcnt_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             h_sync_act_s;
    logic             v_sync_act_s;
    logic             h_blank_s;
    logic             v_blank_s;
    logic             line_origin_s;

    logic             h_sync_r;
    logic             v_sync_r;
    logic             de_r;
    logic             h_blank_r;
    logic             v_blank_r;
    logic             line_start_r;
    logic             frame_start_r;
    logic [CNT_W-1:0] pos_x_r;
    logic [CNT_W-1:0] pos_y_r;
    logic             frame_origin_r;  // counters currently sit on pixel (0,0)

    assign pix_en_s = vif.pix_en;

    vga_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_en      (pix_en_s),
        .timing      (H_AXIS),
        .count       (hcnt_s),
        .wrap        (h_wrap_s),
        .sync_active (h_sync_act_s),
        .blank       (h_blank_s)
    );

    // Lines advance only on the pixel that closes the current line, so vsync
    // edges line up with the horizontal wrap rather than with hsync.
    vga_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_en      (pix_en_s & h_wrap_s),
        .timing      (V_AXIS),
        .count       (vcnt_s),
        .wrap        (v_wrap_s),
        .sync_active (v_sync_act_s),
        .blank       (v_blank_s)
    );

    assign line_origin_s = (hcnt_s == '0);

    // Register all outputs from one counter snapshot; hold everything while pix_en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_sync_r       <= ~H_POL;
            v_sync_r       <= ~V_POL;
            de_r           <= 1'b0;
            h_blank_r      <= 1'b0;
            v_blank_r      <= 1'b0;
            line_start_r   <= 1'b0;
            frame_start_r  <= 1'b0;
            pos_x_r        <= '0;
            pos_y_r        <= '0;
            frame_origin_r <= 1'b1;
        end else if (pix_en_s) begin
            h_sync_r       <= ~(h_sync_act_s ^ H_POL);
            v_sync_r       <= ~(v_sync_act_s ^ V_POL);
            de_r           <= ~h_blank_s & ~v_blank_s;
            h_blank_r      <= h_blank_s;
            v_blank_r      <= v_blank_s;
            line_start_r   <= line_origin_s;
            frame_start_r  <= frame_origin_r;
            pos_x_r        <= hcnt_s;
            pos_y_r        <= vcnt_s;
            frame_origin_r <= h_wrap_s & v_wrap_s;
        end
    end

    assign vif.vga_h_sync  = h_sync_r;
    assign vif.vga_v_sync  = v_sync_r;
    assign vif.de          = de_r;
    assign vif.h_blank     = h_blank_r;
    assign vif.v_blank     = v_blank_r;
    assign vif.line_start  = line_start_r;
    assign vif.frame_start = frame_start_r;
    assign vif.pos_x       = pos_x_r;
    assign vif.pos_y       = pos_y_r;

`ifdef VTG_FRAME_CNT_EN
    logic [7:0] frame_count_r;
    logic       awaiting_first_r;  // no pixel accepted since reset

    // Count completed frames; the frame opened by the first pixel after reset is frame 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count_r    <= 8'd0;
            awaiting_first_r <= 1'b1;
        end else if (pix_en_s) begin
            awaiting_first_r <= 1'b0;
            if (frame_origin_r && !awaiting_first_r) begin
                frame_count_r <= frame_count_r + 8'd1;
            end
        end
    end

    assign vif.frame_count = frame_count_r;
`else
    // Frame counter not built; frame_origin_r alone drives frame_start.
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: two small modes (active-low and active-high
// sync), a constant vector table, hand sequences for periods/reset, and a
// randomized run checked every cycle against an arithmetic raster model.
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    localparam int CW = 12;

    typedef struct packed {
        int ha; int hfp; int hsw; int hbp;
        int va; int vfp; int vsw; int vbp;
        bit hp; bit vp;
    } mode_t;

    localparam mode_t M0 = '{ha: 8, hfp: 2, hsw: 3, hbp: 2, va: 4, vfp: 1, vsw: 2, vbp: 1, hp: 1'b0, vp: 1'b0};
    localparam mode_t M1 = '{ha: 6, hfp: 1, hsw: 2, hbp: 3, va: 3, vfp: 2, vsw: 2, vbp: 2, hp: 1'b1, vp: 1'b1};

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic de; logic hb; logic vb; logic hs; logic vs; logic ls; logic fs;
    } obs_t;

    typedef struct {
        logic r;
        logic e;
        obs_t exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   n_en;     // pix_en edges accepted since the last reset

    vga_timing_generator_if #(.CNT_W(CW)) if0 ();
    vga_timing_generator_if #(.CNT_W(CW)) if1 ();

    vga_timing_generator #(
        .H_ACTIVE(M0.ha), .H_FP(M0.hfp), .H_SYNC(M0.hsw), .H_BP(M0.hbp),
        .V_ACTIVE(M0.va), .V_FP(M0.vfp), .V_SYNC(M0.vsw), .V_BP(M0.vbp),
        .H_POL(M0.hp), .V_POL(M0.vp), .CNT_W(CW)
    ) dut0 (.clk(clk), .rst_n(rst_n), .vif(if0));

    vga_timing_generator #(
        .H_ACTIVE(M1.ha), .H_FP(M1.hfp), .H_SYNC(M1.hsw), .H_BP(M1.hbp),
        .V_ACTIVE(M1.va), .V_FP(M1.vfp), .V_SYNC(M1.vsw), .V_BP(M1.vbp),
        .H_POL(M1.hp), .V_POL(M1.vp), .CNT_W(CW)
    ) dut1 (.clk(clk), .rst_n(rst_n), .vif(if1));

    obs_t obs0;
    obs_t obs1;
    assign obs0 = '{x: if0.pos_x, y: if0.pos_y, de: if0.de, hb: if0.h_blank, vb: if0.v_blank,
                    hs: if0.vga_h_sync, vs: if0.vga_v_sync, ls: if0.line_start, fs: if0.frame_start};
    assign obs1 = '{x: if1.pos_x, y: if1.pos_y, de: if1.de, hb: if1.h_blank, vb: if1.v_blank,
                    hs: if1.vga_h_sync, vs: if1.vga_v_sync, ls: if1.line_start, fs: if1.frame_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int x, input int y, input bit de, input bit hb, input bit vb,
                                input bit hs, input bit vs, input bit ls, input bit fs);
        obs_t o;
        o.x = CW'(x); o.y = CW'(y);
        o.de = de; o.hb = hb; o.vb = vb; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    // Raster model: after n accepted pixels the outputs describe pixel (n-1) of the endless raster.
    function automatic obs_t model(input mode_t m, input int n);
        obs_t o;
        int ht, vt, p, x, y;
        ht = m.ha + m.hfp + m.hsw + m.hbp;
        vt = m.va + m.vfp + m.vsw + m.vbp;
        if (n == 0) begin
            o = mk(0, 0, 1'b0, 1'b0, 1'b0, ~m.hp, ~m.vp, 1'b0, 1'b0);
        end else begin
            p = (n - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
            o = mk(x, y, (x < m.ha) && (y < m.va), x >= m.ha, y >= m.va,
                   ((x >= m.ha + m.hfp) && (x < m.ha + m.hfp + m.hsw)) ? m.hp : ~m.hp,
                   ((y >= m.va + m.vfp) && (y < m.va + m.vfp + m.vsw)) ? m.vp : ~m.vp,
                   x == 0, (x == 0) && (y == 0));
        end
        return o;
    endfunction

    function automatic int exp_fcnt(input mode_t m, input int n);
        int fl;
        fl = (m.ha + m.hfp + m.hsw + m.hbp) * (m.va + m.vfp + m.vsw + m.vbp);
        return (n == 0) ? 0 : (((n - 1) / fl) % 256);
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act x=%0d y=%0d de%b hb%b vb%b hs%b vs%b ls%b fs%b exp x=%0d y=%0d de%b hb%b vb%b hs%b vs%b ls%b fs%b",
                     name, act.x, act.y, act.de, act.hb, act.vb, act.hs, act.vs, act.ls, act.fs,
                     exp.x, exp.y, exp.de, exp.hb, exp.vb, exp.hs, exp.vs, exp.ls, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        check_obs($sformatf("model0 n=%0d", n_en), obs0, model(M0, n_en));
        check_obs($sformatf("model1 n=%0d", n_en), obs1, model(M1, n_en));
`ifdef VTG_FRAME_CNT_EN
        check_int($sformatf("fcnt0 n=%0d", n_en), int'(if0.frame_count), exp_fcnt(M0, n_en));
        check_int($sformatf("fcnt1 n=%0d", n_en), int'(if1.frame_count), exp_fcnt(M1, n_en));
`endif
    endtask

    // One clock: drive at the falling edge, let the rising edge act, sample at the next falling edge.
    task automatic step(input logic r, input logic e);
        rst_n      = r;
        if0.pix_en = e;
        if1.pix_en = e;
        @(posedge clk);
        if (!r) begin
            n_en = 0;
        end else if (e) begin
            n_en++;
        end
        @(negedge clk);
        check_model();
    endtask

    vec_t vecs [9];

    initial begin
        int first0, second0, first1, second1, hs0, vs0, hs1, vs1;
        logic prev0, prev1;
        checks = 0; errors = 0; n_en = 0;
        rst_n = 1'b0; if0.pix_en = 1'b0; if1.pix_en = 1'b0;
        @(negedge clk);

        // Reset, hold while disabled, first pixel, mid-line reset abort, restart.
        vecs[0] = '{1'b0, 1'b1, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        vecs[1] = '{1'b1, 1'b0, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        vecs[2] = '{1'b1, 1'b1, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1)};
        vecs[3] = '{1'b1, 1'b0, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1)};
        vecs[4] = '{1'b1, 1'b1, mk(1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        vecs[5] = '{1'b0, 1'b1, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        vecs[6] = '{1'b1, 1'b1, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1)};
        vecs[7] = '{1'b1, 1'b1, mk(1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        vecs[8] = '{1'b1, 1'b0, mk(1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].r, vecs[i].e);
            check_obs($sformatf("vec%0d", i), obs0, vecs[i].exp);
        end

        // Reset while both syncs are asserted at pixel (11,5).
        step(1'b0, 1'b0);
        for (int i = 0; i < 87; i++) step(1'b1, 1'b1);
        check_obs("at_11_5", obs0, mk(11, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1);
        check_obs("rst_in_vsync", obs0, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(1'b1, 1'b1);
        check_obs("after_rst", obs0, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));

        // Sync pulse totals over one full frame.
        step(1'b0, 1'b0);
        hs0 = 0; vs0 = 0; hs1 = 0; vs1 = 0;
        for (int i = 1; i <= 120; i++) begin
            step(1'b1, 1'b1);
            if (!obs0.hs) hs0++;
            if (!obs0.vs) vs0++;
            if (i <= 108 && obs1.hs) hs1++;
            if (i <= 108 && obs1.vs) vs1++;
        end
        check_int("hsync_cnt0", hs0, 24);
        check_int("vsync_cnt0", vs0, 30);
        check_int("hsync_cnt1", hs1, 18);
        check_int("vsync_cnt1", vs1, 24);

        // frame_start period with pix_en steady high, then toggling every cycle.
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b0, 1'b0);
            first0 = -1; second0 = -1; first1 = -1; second1 = -1;
            prev0 = 1'b0; prev1 = 1'b0;
            for (int i = 1; i <= 600; i++) begin
                step(1'b1, (pass == 0) ? 1'b1 : logic'(i % 2));
                if (obs0.fs && !prev0) begin
                    if (first0 < 0) first0 = i; else if (second0 < 0) second0 = i;
                end
                if (obs1.fs && !prev1) begin
                    if (first1 < 0) first1 = i; else if (second1 < 0) second1 = i;
                end
                prev0 = obs0.fs;
                prev1 = obs1.fs;
            end
            check_int($sformatf("first_fs0 pass%0d", pass), first0, 1);
            check_int($sformatf("period0 pass%0d", pass), second0 - first0, (pass == 0) ? 120 : 240);
            check_int($sformatf("period1 pass%0d", pass), second1 - first1, (pass == 0) ? 108 : 216);
        end

        // Randomized enables with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 1)));
        end

`ifdef VTG_FRAME_CNT_EN
        // 257 frames: the counter reaches 255 and wraps to 0 in frame 256.
        step(1'b0, 1'b0);
        for (int i = 1; i <= 30721; i++) begin
            step(1'b1, 1'b1);
            if (i == 121) check_int("fcnt_frame1", int'(if0.frame_count), 1);
            if (i == 30720) check_int("fcnt_255", int'(if0.frame_count), 255);
        end
        check_int("fcnt_wrap", int'(if0.frame_count), 0);
        check_obs("fcnt_wrap_pos", obs0, mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
